// File: rtl/seg7_reader_pkg.sv
// Shared types, glyph table and sequence modulus for the 7-segment loopback reader.
// SEG7_READER_WRAP15_EN extends the glyph table to A..F and the modulus to 16.
package seg7_pkg;

  typedef logic [0:6] seg_t;   // index 0..6 = segments a..g
  typedef logic [0:3] code_t;  // W,X,Y,Z with W as MSB

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOCKED,
    S_BAD
  } state_t;

`ifdef SEG7_READER_WRAP15_EN
  localparam int MODULUS = 16;
`else
  localparam int MODULUS = 10;
`endif
  localparam int NUM_GLYPHS = MODULUS;

  // Lit-segment form (1 = segment on), indexed by the code it represents.
  localparam seg_t GLYPHS [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic code_t next_code(code_t c);
    return (c == code_t'(MODULUS - 1)) ? '0 : c + 1'b1;
  endfunction

endpackage

// File: rtl/seg7_reader_if.sv
// Segment bus in, recovered digit and status out; master drives segments.
interface seg7_reader_if;
  import seg7_pkg::*;

  seg_t        segments;
  code_t       digit;
  logic        digit_valid;
  logic        invalid;
  logic        seq_err;
  logic [7:0]  err_count;

  modport master (output segments,
                  input  digit, digit_valid, invalid, seq_err, err_count);
  modport slave  (input  segments,
                  output digit, digit_valid, invalid, seq_err, err_count);
endinterface

// File: rtl/seg7_glyph_decode.sv
// Combinational segment-pattern to {code, legal} lookup.
// SEG7_READER_WRAP15_EN (via seg7_pkg) makes the A..F glyphs legal.
module seg7_glyph_decode
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  seg_t  raw,
  output code_t code,
  output logic  legal
);

  seg_t lit;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    lit   = ACTIVE_LOW ? ~raw : raw;
    code  = '0;
    legal = 1'b0;
    for (int i = 0; i < NUM_GLYPHS; i++) begin
      if (lit == GLYPHS[i]) begin
        code  = code_t'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_reader.sv
// Loopback checker: synchronizes and debounces the segment bus, decodes it, and
// flags illegal glyphs and breaks in the +1 sequence. Honours SEG7_READER_WRAP15_EN.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic          PIN_Y2,
  input  logic          KEY_3,
  seg7_reader_if.slave  bus
);

  localparam logic [3:0] STAB_MAX  = 4'(STABLE_CYCLES);
  localparam seg_t       RAW_BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic       clk, rst;
  assign clk = PIN_Y2;
  assign rst = KEY_3;

  seg_t       sync1, s2, s2_prev, last_acc;
  logic [3:0] stab_cnt;
  state_t     state, state_nxt;

  code_t      digit;
  logic       digit_valid, invalid, seq_err;
  logic [7:0] err_count;

  code_t      code;
  logic       legal, accept;
  logic       take_digit, flag_err, invalid_nxt;

  // Sync stages start at the blank pattern so an idle bus after reset is never accepted.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= RAW_BLANK;
      s2       <= RAW_BLANK;
      s2_prev  <= RAW_BLANK;
      stab_cnt <= '0;
    end else begin
      sync1   <= bus.segments;
      s2      <= sync1;
      s2_prev <= s2;
      if (s2 != s2_prev)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + 4'd1;
    end
  end

  // Accept on the edge the counter reaches its limit, once per distinct pattern.
  assign accept = (s2 == s2_prev) && (stab_cnt == STAB_MAX - 4'd1) && (s2 != last_acc);

  seg7_glyph_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_decode (
    .raw   (s2),
    .code  (code),
    .legal (legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY, S_LOCKED, S_BAD:
        if (accept) state_nxt = legal ? S_LOCKED : S_BAD;
      default: state_nxt = S_EMPTY;
    endcase
  end

  // Only a legal accept from S_LOCKED is sequence-checked; S_EMPTY and S_BAD resync.
  always_comb begin
    take_digit  = accept && legal;
    flag_err    = take_digit && (state == S_LOCKED) && (code != next_code(digit));
    invalid_nxt = accept ? !legal : invalid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_acc    <= RAW_BLANK;
      digit       <= '0;
      digit_valid <= 1'b0;
      invalid     <= 1'b0;
      seq_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      if (accept)     last_acc <= s2;
      if (take_digit) digit    <= code;
      digit_valid <= take_digit;
      invalid     <= invalid_nxt;
      seq_err     <= flag_err;
      if (flag_err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  assign bus.digit       = digit;
  assign bus.digit_valid = digit_valid;
  assign bus.invalid     = invalid;
  assign bus.seq_err     = seq_err;
  assign bus.err_count   = err_count;

endmodule
